// File: rtl/ram_burst_reader.sv
// Burst read engine: issues back-to-back RAM reads and streams the words out.
// Optional abort input is compiled in with `define RAM_BURST_READER_ABORT_EN.
module ram_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
`ifdef RAM_BURST_READER_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    // Two spare bits so inflight + count never wraps
    localparam int CW = PW + 2;
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0] addr, last_addr;
    logic [ADDR_WIDTH:0]   len, issued;
    logic [RD_LATENCY-1:0] pipe_v, pipe_l;
    logic [DATA_WIDTH-1:0] fifo_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_l;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count, inflight;
    logic issue, issue_last, push, pop, abort_now;

`ifdef RAM_BURST_READER_ABORT_EN
    assign abort_now = abort && (state == RUN || state == DRAIN);
`else
    assign abort_now = 1'b0;
`endif

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            inflight = inflight + CW'(pipe_v[i]);
    end

    assign issue = (state == RUN) && (issued < len) && !abort_now &&
                   ((inflight + count) < CW'(FIFO_DEPTH));
    assign issue_last = issue && ((issued + ONE) == len);
    assign push = pipe_v[RD_LATENCY-1] && !abort_now;
    assign pop  = m_valid && m_ready;

    assign ram_re    = issue;
    assign ram_raddr = issue ? addr : last_addr;
    assign m_valid   = (count != '0);
    assign m_data    = m_valid ? fifo_d[rd_ptr] : '0;
    assign m_last    = m_valid && fifo_l[rd_ptr];
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == FIN);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = (length == '0) ? FIN : RUN;
            RUN:   if (abort_now) state_nx = FIN;
                   else if (issue_last) state_nx = DRAIN;
            DRAIN: if (abort_now) state_nx = FIN;
                   else if (pop && m_last && inflight == '0) state_nx = FIN;
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            last_addr <= '0;
            len       <= '0;
            issued    <= '0;
            pipe_v    <= '0;
            pipe_l    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                addr   <= start_addr;
                len    <= length;
                issued <= '0;
            end
            if (issue) begin
                addr      <= addr + ADDR_WIDTH'(1);
                last_addr <= addr;
                issued    <= issued + ONE;
            end
            if (abort_now) begin
                pipe_v <= '0;
                pipe_l <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                pipe_v[0] <= issue;
                pipe_l[0] <= issue_last;
                for (int i = 1; i < RD_LATENCY; i++) begin
                    pipe_v[i] <= pipe_v[i-1];
                    pipe_l[i] <= pipe_l[i-1];
                end
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: m_valid gates everything read from it
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_d[wr_ptr] <= ram_rdata;
            fifo_l[wr_ptr] <= pipe_l[RD_LATENCY-1];
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(push && !pop && count == CW'(FIFO_DEPTH)))
            else $error("ram_burst_reader: output FIFO overflow");
    end
`endif
endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: latency-1 and latency-2 instances run the same
// directed bursts against a per-cycle beat model plus literal expectations.
`timescale 1ns/1ps
module tb_ram_burst_reader;
    localparam int DW = 16;
    localparam int AW = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start [2];
    logic [AW-1:0] start_addr [2];
    logic [AW:0]   length [2];
    logic          busy [2];
    logic          done [2];
    logic          ram_re [2];
    logic [AW-1:0] ram_raddr [2];
    logic [DW-1:0] ram_rdata [2];
    logic          m_valid [2];
    logic [DW-1:0] m_data [2];
    logic          m_last [2];
    logic          m_ready [2];
`ifdef RAM_BURST_READER_ABORT_EN
    logic          abort [2];
`endif
    logic [DW-1:0] mem [32];

    initial for (int i = 0; i < 32; i++) mem[i] = DW'(i);

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [DW-1:0] r1, r2;
        ram_burst_reader #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
            .RD_LATENCY(g + 1), .FIFO_DEPTH(DEPTH)
        ) dut (
            .clk(clk), .rst(rst),
            .start(start[g]), .start_addr(start_addr[g]), .length(length[g]),
`ifdef RAM_BURST_READER_ABORT_EN
            .abort(abort[g]),
`endif
            .busy(busy[g]), .done(done[g]),
            .ram_re(ram_re[g]), .ram_raddr(ram_raddr[g]), .ram_rdata(ram_rdata[g]),
            .m_valid(m_valid[g]), .m_data(m_data[g]), .m_last(m_last[g]),
            .m_ready(m_ready[g])
        );
        always @(posedge clk) begin
            if (ram_re[g]) r1 <= mem[ram_raddr[g]];
            r2 <= r1;
        end
        assign ram_rdata[g] = (g == 0) ? r1 : r2;
    end

    int checks, errors, cyc, rp, ready_mode, start_cyc;
    bit act [2], xdone [2], post_rst [2], prev_stall [2], aborted [2];
    int base [2], blen [2], iss [2], pop_n [2], hold [2];
    int avail [2][64];
    logic [DW-1:0] prev_data [2];
    logic prev_last [2];
    int got [2][64];
    int ngot [2], done_n [2], done_cyc [2], re_n [2], first_re [2], last_re [2];
    int first_v [2], vld_n [2], pause_n [2], re_after [2];
    int t2_exp [8] = '{28, 29, 30, 31, 0, 1, 2, 3};

    task automatic chk(input string nm, input int i, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s inst%0d cyc=%0d got=%0d expected=%0d", nm, i, cyc, a, e);
        end
    endtask

    // Beat-level model: beat k issued at cycle c is visible from c+LAT+1 until popped
    task automatic model_step();
        cyc++;
        for (int i = 0; i < 2; i++) begin
            bit ev, er, xfer, ab, idle, nd;
            int ea;
            if (rst) begin
                act[i] = 0; xdone[i] = 0; iss[i] = 0; pop_n[i] = 0;
                blen[i] = 0; base[i] = 0; hold[i] = 0;
                prev_stall[i] = 0; post_rst[i] = 1;
                continue;
            end
            if (post_rst[i]) begin
                chk("rst_ram_re", i, ram_re[i], 0);
                chk("rst_ram_raddr", i, ram_raddr[i], 0);
                chk("rst_m_valid", i, m_valid[i], 0);
                chk("rst_m_data", i, m_data[i], 0);
                chk("rst_m_last", i, m_last[i], 0);
                chk("rst_busy", i, busy[i], 0);
                chk("rst_done", i, done[i], 0);
                post_rst[i] = 0;
            end
            ab = 0;
`ifdef RAM_BURST_READER_ABORT_EN
            ab = act[i] && abort[i];
`endif
            ev = (pop_n[i] < iss[i]) && (avail[i][pop_n[i]] <= cyc);
            er = act[i] && !ab && (iss[i] < blen[i]) && (iss[i] - pop_n[i] < DEPTH);
            ea = (base[i] + iss[i]) % 32;
            chk("busy", i, busy[i], act[i]);
            chk("done", i, done[i], xdone[i]);
            chk("ram_re", i, ram_re[i], er);
            chk("ram_raddr", i, ram_raddr[i], er ? ea : hold[i]);
            chk("m_valid", i, m_valid[i], ev);
            if (ev) begin
                chk("m_data", i, m_data[i], (base[i] + pop_n[i]) % 32);
                chk("m_last", i, m_last[i], pop_n[i] == blen[i] - 1);
            end
            if (prev_stall[i]) begin
                chk("stall_data", i, m_data[i], prev_data[i]);
                chk("stall_last", i, m_last[i], prev_last[i]);
            end
            if (done[i]) begin done_n[i]++; done_cyc[i] = cyc; end
            if (ram_re[i]) begin
                if (first_re[i] < 0) first_re[i] = cyc;
                last_re[i] = cyc;
                re_n[i]++;
                if (aborted[i]) re_after[i]++;
            end
            if (m_valid[i]) begin
                vld_n[i]++;
                if (first_v[i] < 0) first_v[i] = cyc;
            end
            if (m_valid[i] && m_ready[i] && ngot[i] < 64) begin
                got[i][ngot[i]] = m_data[i];
                ngot[i]++;
            end
            if (act[i] && !ram_re[i] && iss[i] < blen[i]) pause_n[i]++;
            idle = !act[i] && !xdone[i];
            nd = 0;
            xfer = ev && m_ready[i];
            if (er) begin
                avail[i][iss[i]] = cyc + i + 2;
                hold[i] = ea;
                iss[i]++;
            end
            if (xfer) begin
                pop_n[i]++;
                if (pop_n[i] == blen[i]) begin act[i] = 0; nd = 1; end
            end
            if (ab) begin
                act[i] = 0; pop_n[i] = iss[i]; nd = 1; aborted[i] = 1;
            end
            if (idle && start[i]) begin
                if (length[i] == 0) nd = 1;
                else begin
                    act[i] = 1; base[i] = start_addr[i]; blen[i] = length[i];
                    iss[i] = 0; pop_n[i] = 0;
                end
            end
            xdone[i] = nd;
            prev_stall[i] = ev && !m_ready[i];
            prev_data[i] = m_data[i];
            prev_last[i] = m_last[i];
        end
    endtask

    task automatic tick();
        for (int i = 0; i < 2; i++)
            m_ready[i] = (ready_mode == 0) ? 1'b1 : ((rp % 4 == 0) || (rp % 4 == 3));
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        rp++;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin
            ngot[i] = 0; done_n[i] = 0; done_cyc[i] = -1; re_n[i] = 0;
            first_re[i] = -1; last_re[i] = -1; first_v[i] = -1; vld_n[i] = 0;
            pause_n[i] = 0; re_after[i] = 0; aborted[i] = 0;
        end
    endtask

    task automatic issue(input int a, input int n);
        clear_logs();
        start_cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b1; start_addr[i] = AW'(a); length[i] = (AW + 1)'(n);
        end
        tick();
        for (int i = 0; i < 2; i++) start[i] = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (done_n[0] > 0 && done_n[1] > 0) break;
            tick();
        end
        tick();
        tick();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; rp = 0; ready_mode = 0; start_cyc = 0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; start_addr[i] = '0; length[i] = '0; m_ready[i] = 1'b1;
`ifdef RAM_BURST_READER_ABORT_EN
            abort[i] = 1'b0;
`endif
        end
        clear_logs();
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        issue(1, 31);
        wait_done(120);
        for (int i = 0; i < 2; i++) begin
            chk("t1_done_n", i, done_n[i], 1);
            chk("t1_beats", i, ngot[i], 31);
            for (int k = 0; k < ngot[i]; k++) chk("t1_data", i, got[i][k], k + 1);
            chk("t1_re_n", i, re_n[i], 31);
            chk("t1_re_span", i, last_re[i] - first_re[i], 30);
            chk("t1_first_valid", i, first_v[i] - first_re[i], i + 2);
        end

        issue(28, 8);
        wait_done(60);
        for (int i = 0; i < 2; i++) begin
            chk("t2_done_n", i, done_n[i], 1);
            chk("t2_beats", i, ngot[i], 8);
            for (int k = 0; k < ngot[i] && k < 8; k++) chk("t2_data", i, got[i][k], t2_exp[k]);
        end

        ready_mode = 1;
        rp = 0;
        issue(0, 10);
        wait_done(200);
        ready_mode = 0;
        for (int i = 0; i < 2; i++) begin
            chk("t3_done_n", i, done_n[i], 1);
            chk("t3_beats", i, ngot[i], 10);
            for (int k = 0; k < ngot[i]; k++) chk("t3_data", i, got[i][k], k);
            chk("t3_pause", i, pause_n[i] > 0, 1);
        end

        issue(5, 0);
        wait_done(20);
        for (int i = 0; i < 2; i++) begin
            chk("t4_done_n", i, done_n[i], 1);
            chk("t4_done_lat", i, done_cyc[i] - start_cyc, 1);
            chk("t4_re_n", i, re_n[i], 0);
            chk("t4_valid_n", i, vld_n[i], 0);
        end

        issue(0, 20);
        for (int k = 0; k < 100 && ngot[0] < 5; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 2; i++) chk("t5_no_done", i, done_n[i], 0);
        issue(0, 3);
        wait_done(60);
        for (int i = 0; i < 2; i++) begin
            chk("t5_done_n", i, done_n[i], 1);
            chk("t5_beats", i, ngot[i], 3);
            for (int k = 0; k < ngot[i]; k++) chk("t5_data", i, got[i][k], k);
        end

`ifdef RAM_BURST_READER_ABORT_EN
        issue(0, 16);
        for (int k = 0; k < 100 && ngot[0] < 4; k++) tick();
        for (int i = 0; i < 2; i++) abort[i] = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) abort[i] = 1'b0;
        for (int i = 0; i < 2; i++) chk("t6_valid_after", i, m_valid[i], 0);
        wait_done(60);
        repeat (4) tick();
        for (int i = 0; i < 2; i++) begin
            chk("t6_done_n", i, done_n[i], 1);
            chk("t6_re_after", i, re_after[i], 0);
            chk("t6_beats", i, ngot[i], 5 - i);
            for (int k = 0; k < ngot[i]; k++) chk("t6_data", i, got[i][k], k);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
